instr_encoder_loader: RTL

Encodes symbolic instructions (mnemonic plus register, immediate and target fields) into 32-bit MIPS words and writes them sequentially into instruction memory. It is the inverse of the control decoder and emits only the instruction classes that decoder supports. It sits in front of instruction memory during program load, before the monocycle core runs. Input uses a valid/ready handshake; output is a single-word write port with an auto-incrementing address.

---
 rtl/instr_encoder_loader_if.sv | 26 ++
 rtl/instr_encoder_loader.sv | 87 ++++++++
 2 files changed

// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: mnemonic input handshake plus instruction-memory write port.
//   master: drives in_valid and the mnemonic fields, observes in_ready and the imem write port
//   slave : the loader side, accepts mnemonics and drives the imem write port
interface instr_encoder_loader_if #(
    parameter int AW = 6
);
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [4:0]    in_rd;
    logic [15:0]   in_imm;
    logic [25:0]   in_target;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic MIPS mnemonics and writes them sequentially into instruction memory.
//   clk, rst : clock and synchronous active-high reset
//   start    : one-cycle pulse that opens a load session (ignored while loading)
//   bus      : mnemonic valid/ready input and registered imem write port (word address auto-increments)
//   count    : words written this session
//   done     : session finished (END seen or memory full)
//   err      : sticky, set by an invalid mnemonic until the next start or rst
module instr_encoder_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    instr_encoder_loader_if.slave        bus,
    output logic [AW:0]                  count,
    output logic                         done,
    output logic                         err
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    state_t state, state_n;
    logic xfer, enc_ok, bad, clr;
    logic [31:0] enc;
    assign bus.in_ready = state == LOAD && count < FULL;
    assign xfer = bus.in_valid && bus.in_ready;
    assign done = state == DONE;
    assign clr = start && state != LOAD;
    always_comb begin
        enc = '0;
        enc_ok = 1'b1;
        bad = 1'b0;
        case (bus.in_op)
            4'd0: enc = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100000};
            4'd1: enc = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100010};
            4'd2: enc = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100100};
            4'd3: enc = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100101};
            4'd4: enc = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b101010};
            4'd5: enc = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd6: enc = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd7: enc = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd8: enc = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd9: enc = {6'b000010, bus.in_target};
            4'd15: enc_ok = 1'b0;
            default: begin
                enc_ok = 1'b0;
                bad = 1'b1;
            end
        endcase
    end
    // leave LOAD on END, or on the word that fills the memory
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = LOAD;
            LOAD: if (xfer && (bus.in_op == 4'd15 || (enc_ok && count == FULL - 1'b1))) state_n = DONE;
            DONE: if (start) state_n = LOAD;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // count doubles as the write pointer: both clear on start and advance together
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.imem_we <= 1'b0;
            bus.imem_addr <= '0;
            bus.imem_wdata <= '0;
            count <= '0;
            err <= 1'b0;
        end else begin
            bus.imem_we <= xfer && enc_ok;
            if (xfer && enc_ok) begin
                bus.imem_addr <= count[AW-1:0];
                bus.imem_wdata <= enc;
                count <= count + 1'b1;
            end
            if (xfer && bad) err <= 1'b1;
            if (clr) begin
                count <= '0;
                err <= 1'b0;
            end
        end
    end
endmodule
